// File: rtl/fb_ahb_slave.sv
// rtl/fb_ahb_slave.sv - AHB-Lite pixel write slave feeding a buffered framebuffer memory port
// Optional ERROR response for invalid transfers: define FB_SLV_ERR_RESP_EN.
module fb_ahb_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        mem_wen,
    output logic [8:0]  mem_x,
    output logic [8:0]  mem_y,
    output logic [23:0] mem_wdata,
    input  logic        mem_ready
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [31:0] FB_BYTES = 32'd614400;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef FB_SLV_ERR_RESP_EN
        ERR1,
        ERR2,
`endif
        STALL
    } state_t;

`ifdef FB_SLV_ERR_RESP_EN
    localparam state_t BAD_NEXT = ERR1;
`else
    localparam state_t BAD_NEXT = IDLE;
`endif

    state_t state;

    logic [31:0] offset;
    logic        xfer_ok;
    logic [11:0] blk;
    logic [28:0] y_prod;
    logic [8:0]  addr_y;
    logic [19:0] row_base;
    logic [19:0] row_off;
    logic [8:0]  addr_x;

    assign offset  = HADDR - BASE_ADDR;
    assign xfer_ok = HWRITE && (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) &&
                     (HADDR >= BASE_ADDR) && (offset < FB_BYTES);

    // offset/1280 == (offset>>8)/5; the reciprocal multiply is exact for in-range offsets
    assign blk      = offset[19:8];
    assign y_prod   = {17'd0, blk} * 29'd52429;
    assign addr_y   = y_prod[26:18];
    assign row_base = {11'd0, addr_y} * 20'd1280;
    assign row_off  = offset[19:0] - row_base;
    assign addr_x   = row_off[10:2];

    logic [8:0]    cap_x;
    logic [8:0]    cap_y;
    logic [41:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] nxt_rd;
    logic [CW-1:0] count;
    logic [CW-1:0] nxt_count;
    logic [41:0]   push_entry;
    logic [41:0]   head_next;
    logic          pop;
    logic          space;
    logic          in_data;
    logic          push;
    logic          capture;

    assign pop        = mem_wen & mem_ready;
    assign space      = (count != CW'(FIFO_DEPTH)) | pop;
    assign in_data    = (state == DATA) || (state == STALL);
    assign push       = in_data & space;
    assign push_entry = {cap_x, cap_y, HWDATA[23:0]};
    assign capture    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign nxt_rd     = rd_ptr + PW'(pop);
    assign nxt_count  = count + CW'(push) - CW'(pop);
    // The registered head must see an entry written this same cycle
    assign head_next  = (push && (wr_ptr == nxt_rd)) ? push_entry : fifo_mem[nxt_rd];

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            DATA, STALL: HREADYOUT = space;
`ifdef FB_SLV_ERR_RESP_EN
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ERR2: HRESP = 1'b1;
`endif
            default: ;
        endcase
    end

    assign HRDATA = 32'h0;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cap_x     <= '0;
            cap_y     <= '0;
            mem_wen   <= 1'b0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_wdata <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            rd_ptr  <= nxt_rd;
            count   <= nxt_count;
            mem_wen <= (nxt_count != '0);
            {mem_x, mem_y, mem_wdata} <= head_next;
            if (capture) begin
                cap_x <= addr_x;
                cap_y <= addr_y;
            end
            if (in_data && !space) begin
                state <= STALL;
            end
`ifdef FB_SLV_ERR_RESP_EN
            else if (state == ERR1) begin
                state <= ERR2;
            end
`endif
            else if (capture) begin
                state <= xfer_ok ? DATA : BAD_NEXT;
            end else begin
                state <= IDLE;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HWDATA[31:24], y_prod[28:27], y_prod[17:0],
                           row_off[19:11], row_off[1:0]};

endmodule

// File: tb/tb_fb_ahb_slave.sv
// tb/tb_fb_ahb_slave.sv - self-checking bench for fb_ahb_slave
module tb_fb_ahb_slave;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 4;
`ifdef FB_SLV_ERR_RESP_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        clk;
    logic        n_rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        mem_wen;
    logic [8:0]  mem_x;
    logic [8:0]  mem_y;
    logic [23:0] mem_wdata;
    logic        mem_ready;
    logic [1:0]  mr_mode;
    logic        mr_rand;

    fb_ahb_slave #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .mem_wen(mem_wen), .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign HREADY    = HREADYOUT;
    assign mem_ready = (mr_mode == 2'd2) ? mr_rand : mr_mode[0];
    always @(posedge clk) mr_rand <= 1'($urandom_range(0, 1));

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [23:0] d;
    } pix_t;

    pix_t obs_q[$];
    pix_t exp_q[$];

    always @(negedge clk) begin
        if (mem_wen && mem_ready) obs_q.push_back({mem_x, mem_y, mem_wdata});
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] t_addr [64];
    logic [31:0] t_data [64];
    logic        t_write[64];
    logic [2:0]  t_size [64];
    int          t_waits[64];
    int          t_errc [64];
    bit          t_ok   [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel mapping written straight from the address arithmetic
    function automatic bit pix_of(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                  input logic [31:0] d, output pix_t p);
        int unsigned off;
        off = a - BASE;
        p.x = 9'((off % 1280) / 4);
        p.y = 9'(off / 1280);
        p.d = d[23:0];
        return w && (sz == 3'd2) && (a % 4 == 0) && (a >= BASE) && (off < 614400);
    endfunction

    task automatic drive_addr(input int i, input int n);
        if (i < n) begin
            HSEL   = 1'b1;
            HTRANS = 2'b10;
            HADDR  = t_addr[i];
            HWRITE = t_write[i];
            HSIZE  = t_size[i];
        end else begin
            HSEL   = 1'b0;
            HTRANS = 2'b00;
        end
    endtask

    task automatic run_burst(input int n, input bit zero_wait_valid);
        int   cur_a;
        int   cur_d;
        int   budget;
        bit   rdy;
        bit   resp;
        pix_t p;
        for (int i = 0; i < n; i++) begin
            t_waits[i] = 0;
            t_errc[i]  = 0;
            t_ok[i]    = pix_of(t_addr[i], t_write[i], t_size[i], t_data[i], p);
            if (t_ok[i]) exp_q.push_back(p);
        end
        @(posedge clk); #1;
        cur_a  = 0;
        cur_d  = -1;
        budget = 0;
        drive_addr(cur_a, n);
        while ((cur_a < n || cur_d >= 0) && budget < 400) begin
            @(negedge clk);
            rdy  = HREADYOUT;
            resp = HRESP;
            if (cur_d >= 0) begin
                if (!rdy) t_waits[cur_d]++;
                if (resp) t_errc[cur_d]++;
                if (rdy) check("hrdata", 64'(HRDATA), 64'h0);
            end
            @(posedge clk); #1;
            budget++;
            if (rdy) begin
                cur_d = (cur_a < n) ? cur_a : -1;
                if (cur_d >= 0) HWDATA = t_data[cur_d];
                if (cur_a < n) cur_a++;
                drive_addr(cur_a, n);
            end
        end
        check("burst_done", 64'(budget < 400), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (t_ok[i]) begin
                if (zero_wait_valid) check($sformatf("wait[%0d]", i), 64'(t_waits[i]), 64'd0);
                check($sformatf("okresp[%0d]", i), 64'(t_errc[i]), 64'd0);
            end else begin
                check($sformatf("badwait[%0d]", i), 64'(t_waits[i]), 64'(ERR_EN));
                check($sformatf("badresp[%0d]", i), 64'(t_errc[i]), 64'(2 * ERR_EN));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        mr_mode = 2'd1;
        while (n < 50) begin
            @(negedge clk);
            if (!mem_wen) break;
            n++;
        end
        check("drain", 64'(mem_wen), 64'd0);
    endtask

    task automatic compare_q(input string tag);
        int m;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_pix[%0d]", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic set_xfer(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [2:0] sz);
        t_addr[i]  = a;
        t_data[i]  = d;
        t_write[i] = w;
        t_size[i]  = sz;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst   = 1'b1;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'd0;
        HWDATA  = '0;
        mr_mode = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check("rst_hresp", 64'(HRESP), 64'd0);
        check("rst_hrdata", 64'(HRDATA), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_bus", 64'({mem_x, mem_y, mem_wdata}), 64'd0);
        n_rst = 1'b0;

        // Last pixel of the first row
        set_xfer(0, BASE + 32'h4FC, 32'h00FF_0000, 1'b1, 3'd2);
        run_burst(1, 1'b1);
        drain();
        check("row0_last", 64'(obs_q[0]), 64'({9'd319, 9'd0, 24'hFF0000}));
        compare_q("t1");

        // Last pixel of the framebuffer and the first byte past it
        set_xfer(0, BASE + 32'd614396, 32'hAB12_3456, 1'b1, 3'd2);
        set_xfer(1, BASE + 32'd614400, 32'h0000_0001, 1'b1, 3'd2);
        run_burst(2, 1'b1);
        drain();
        check("fb_last", 64'(obs_q[0]), 64'({9'd319, 9'd479, 24'h123456}));
        compare_q("t2");

        // Six back-to-back writes against a blocked memory port
        mr_mode = 2'd0;
        for (int i = 0; i < 6; i++)
            set_xfer(i, BASE + 32'(1280 * (i + 1) + 8 * i), 32'h0100_0000 * i + 32'h10 * i, 1'b1, 3'd2);
        fork
            run_burst(6, 1'b0);
            begin
                repeat (12) @(posedge clk);
                #1 mr_mode = 2'd1;
            end
        join
        for (int i = 0; i < 4; i++) check($sformatf("pre_full_wait[%0d]", i), 64'(t_waits[i]), 64'd0);
        check("fifth_stalled", 64'(t_waits[4] >= 5), 64'd1);
        check("sixth_wait", 64'(t_waits[5]), 64'd0);
        drain();
        compare_q("t3");

        // Read and halfword write are both rejected
        set_xfer(0, BASE + 32'h40, 32'h0011_2233, 1'b0, 3'd2);
        set_xfer(1, BASE + 32'h44, 32'h0044_5566, 1'b1, 3'd1);
        run_burst(2, 1'b1);
        drain();
        compare_q("t4");

        // Reset while stalled with a full FIFO
        mr_mode = 2'd0;
        @(posedge clk); #1;
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) begin
                HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 32'(4 * k); HWRITE = 1'b1; HSIZE = 3'd2;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            if (k > 0) HWDATA = 32'h100 + 32'(k - 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_hreadyout", 64'(HREADYOUT), 64'd0);
        check("stall_mem_wen", 64'(mem_wen), 64'd1);
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(negedge clk);
        check("post_rst_mem_wen", 64'(mem_wen), 64'd0);
        check("post_rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check("post_rst_hresp", 64'(HRESP), 64'd0);
        check("post_rst_mem_bus", 64'({mem_x, mem_y, mem_wdata}), 64'd0);
        mr_mode = 2'd1;
        repeat (3) @(negedge clk);
        check("post_rst_no_writes", 64'(obs_q.size()), 64'd0);
        set_xfer(0, BASE + 32'd2564, 32'h00C0_FFEE, 1'b1, 3'd2);
        run_burst(1, 1'b1);
        drain();
        compare_q("t5");

        // Randomized mix of valid and invalid transfers with a flaky memory port
        for (int r = 0; r < 3; r++) begin
            mr_mode = 2'd2;
            for (int i = 0; i < 16; i++) begin
                logic [31:0] a;
                case ($urandom_range(0, 5))
                    0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 153599));
                    3:       a = BASE + 32'd614400 + 32'(4 * $urandom_range(0, 1000));
                    4:       a = BASE - 32'(4 * $urandom_range(1, 1000));
                    default: a = BASE + 32'(4 * $urandom_range(0, 1000) + $urandom_range(1, 3));
                endcase
                set_xfer(i, a, $urandom, 1'($urandom_range(0, 7) != 0),
                         ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2);
            end
            run_burst(16, 1'b0);
            drain();
            compare_q($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
